// File: rtl/mac_unit_pkg.sv
// mac_unit_pkg: shared definitions for the execute-stage ALU and MAC unit.
//   - ALU control codes, shared by ALU control, the ALU and mac_unit.
//   - mac_unit FSM state encoding.
package mac_unit_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SLL = 4'd3;
    localparam logic [3:0] ALU_SRL = 4'd4;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2,
        StRsvd = 2'd3
    } mac_state_e;

endpackage

// File: rtl/shift_add_core.sv
// shift_add_core: iterative shift-add multiplier datapath (no accumulate knowledge).
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_load           load multiplicand/multiplier, clear product and count
//   i_step           perform one shift-add iteration
//   i_mcand          multiplicand to load
//   i_mplier         multiplier to load
//   o_prod_next      product including the current iteration's add
//   o_last           current iteration is the final one
module shift_add_core #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [DATA_W-1:0] i_mcand,
    input  logic [DATA_W-1:0] i_mplier,
    output logic [DATA_W-1:0] o_prod_next,
    output logic              o_last
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [DATA_W-1:0] r_prod;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] w_prod_next;

    // Exposed so the final edge can use the complete product without an extra cycle.
    assign w_prod_next = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
    assign o_prod_next = w_prod_next;
    assign o_last      = (r_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_mcand  <= i_mcand;
            r_mplier <= i_mplier;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (i_step) begin
            r_prod   <= w_prod_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mac_unit.sv
// mac_unit: sequential multiply / multiply-accumulate unit with architectural accumulator.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start           request (ignored while running)
//   i_alu_control     ALU control code; only MUL_OP starts the unit
//   i_mac_select      1 = accumulate into acc, 0 = plain multiply
//   i_operand_a/b     multiplicand / multiplier
//   i_acc_clear       clear accumulator at next edge (wins over a MAC update)
//   o_busy            high while iterating (pipeline stall)
//   o_done            one-cycle pulse, o_result valid
//   o_result          registered result, held until next completion
//   o_acc             accumulator value
module mac_unit
    import mac_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter logic [3:0]  MUL_OP = ALU_MUL
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [3:0]        i_alu_control,
    input  logic              i_mac_select,
    input  logic [DATA_W-1:0] i_operand_a,
    input  logic [DATA_W-1:0] i_operand_b,
    input  logic              i_acc_clear,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_result,
    output logic [DATA_W-1:0] o_acc
);

    mac_state_e        r_state;
    mac_state_e        w_state_d;
    logic              r_mac;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_result;

    logic              w_accept;
    logic              w_load;
    logic              w_step;
    logic              w_final;
    logic              w_last;
    logic [DATA_W-1:0] w_prod_next;
    logic [DATA_W-1:0] w_sum;

    assign w_accept = i_start && (i_alu_control == MUL_OP) && (r_state != StRun);

    shift_add_core #(
        .DATA_W(DATA_W)
    ) u_core (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_mcand    (i_operand_a),
        .i_mplier   (i_operand_b),
        .o_prod_next(w_prod_next),
        .o_last     (w_last)
    );

    always_comb begin
        w_state_d = r_state;
        w_load    = 1'b0;
        w_step    = 1'b0;
        w_final   = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_load    = 1'b1;
                    w_state_d = StRun;
                end
            end
            StRun: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_final   = 1'b1;
                    w_state_d = StDone;
                end
            end
            StDone: begin
                // Back-to-back accept skips IDLE.
                if (w_accept) begin
                    w_load    = 1'b1;
                    w_state_d = StRun;
                end else begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mac <= 1'b0;
        end else if (w_load) begin
            r_mac <= i_mac_select;
        end
    end

    assign w_sum = r_acc + w_prod_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_acc_clear) begin
            r_acc <= '0;
        end else if (w_final && r_mac) begin
            r_acc <= w_sum;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_result <= '0;
        end else if (w_final) begin
            r_result <= r_mac ? w_sum : w_prod_next;
        end
    end

    assign o_busy   = (r_state == StRun);
    assign o_done   = (r_state == StDone);
    assign o_result = r_result;
    assign o_acc    = r_acc;

endmodule

// File: tb/tb_mac_unit.sv
// tb_mac_unit: scoreboard bench for mac_unit. Expected {result, acc} pairs are
// computed from plain a*b arithmetic when an operation is issued; a monitor pops
// and compares them whenever o_done is seen.
module tb_mac_unit;
    import mac_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  alu;
    logic        mac_sel;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        acc_clear;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] acc;

    mac_unit #(
        .DATA_W(32),
        .MUL_OP(ALU_MUL)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_alu_control(alu),
        .i_mac_select (mac_sel),
        .i_operand_a  (opa),
        .i_operand_b  (opb),
        .i_acc_clear  (acc_clear),
        .o_busy       (busy),
        .o_done       (done),
        .o_result     (result),
        .o_acc        (acc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] acc;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    logic [31:0] acc_m = '0;
    logic [31:0] res_m = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_acc();
        acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0;
        acc_m = '0;
        check("acc_after_clear", acc, 32'd0);
        check("result_held_on_clear", result, res_m);
    endtask

    // Issues one accepted operation and follows it to its DONE cycle.
    // inject_cyc != 0 pulses a (to-be-ignored) start in that RUN cycle.
    task automatic do_op(input logic [31:0] a_i, input logic [31:0] b_i, input logic mac_i,
                         input logic clear_last, input int inject_cyc);
        logic [63:0] p;
        int          busy_n;
        p     = 64'(a_i) * 64'(b_i);
        res_m = mac_i ? (acc_m + p[31:0]) : p[31:0];
        if (clear_last) acc_m = '0;
        else if (mac_i) acc_m = res_m;
        q.push_back('{res: res_m, acc: acc_m});

        start = 1'b1; alu = ALU_MUL; opa = a_i; opb = b_i; mac_sel = mac_i;
        tick();
        start = 1'b0; opa = $urandom; opb = $urandom; mac_sel = 1'($urandom);
        busy_n = 0;
        for (int c = 1; c <= 32; c++) begin
            if (busy) busy_n++;
            if (c == inject_cyc) begin
                start = 1'b1; alu = ALU_MUL; opa = $urandom; opb = $urandom;
                mac_sel = 1'($urandom);
            end
            if (c == 32 && clear_last) acc_clear = 1'b1;
            tick();
            start = 1'b0;
            acc_clear = 1'b0;
        end
        check("busy_cycles", 32'(busy_n), 32'd32);
        check("done_in_cycle_33", 32'(done), 32'd1);
        check("busy_low_in_done", 32'(busy), 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                done_cnt++;
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_done: got done=1 result=%h, expected no done", result);
                end else begin
                    e = q.pop_front();
                    check("result", result, e.res);
                    check("acc_at_done", acc, e.acc);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int d0;
        int seen;
        rst = 1'b1; start = 1'b0; alu = ALU_ADD; mac_sel = 1'b0;
        opa = '0; opb = '0; acc_clear = 1'b0;
        idle(3);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_acc", acc, 32'd0);
        rst = 1'b0;
        idle(2);

        // MUL 7 x 6
        do_op(32'd7, 32'd6, 1'b0, 1'b0, 0);
        idle(2);
        check("mul_acc_untouched", acc, 32'd0);

        // MAC 3x4 then 5x5 back-to-back
        do_op(32'd3, 32'd4, 1'b1, 1'b0, 0);
        do_op(32'd5, 32'd5, 1'b1, 1'b0, 0);
        idle(3);
        check("mac_acc_37", acc, 32'd37);
        check("result_held_37", result, 32'd37);

        // Overflow
        do_op(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 0);
        idle(1);
        clear_acc();
        do_op(32'd1, 32'd5, 1'b1, 1'b0, 0);
        idle(1);
        do_op(32'h8000_0000, 32'd2, 1'b1, 1'b0, 0);
        idle(2);
        check("ovf_acc_5", acc, 32'd5);

        // Non-MUL code never starts the unit
        start = 1'b1; alu = ALU_ADD; opa = 32'd9; opb = 32'd9; mac_sel = 1'b0;
        tick();
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy || done) seen++;
            tick();
        end
        check("reject_add_activity", 32'(seen), 32'd0);

        // start in RUN cycle 10 is ignored and not queued
        d0 = done_cnt;
        do_op(32'd9, 32'd11, 1'b0, 1'b0, 10);
        idle(40);
        check("single_done_after_ignored_start", 32'(done_cnt - d0), 32'd1);

        // Reset mid-MAC
        clear_acc();
        do_op(32'd3, 32'd3, 1'b1, 1'b0, 0);
        idle(1);
        check("acc_9_before_reset", acc, 32'd9);
        start = 1'b1; alu = ALU_MUL; opa = 32'd4; opb = 32'd4; mac_sel = 1'b1;
        tick();
        start = 1'b0;
        idle(14);
        check("busy_cycle_15", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        acc_m = '0; res_m = '0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_acc", acc, 32'd0);
        check("rst_result", result, 32'd0);
        idle(40);

        // acc_clear coinciding with MAC final edge
        do_op(32'd2, 32'd5, 1'b1, 1'b0, 0);
        idle(2);
        check("acc_10", acc, 32'd10);
        do_op(32'd2, 32'd3, 1'b1, 1'b1, 0);
        tick();
        check("clear_wins_acc", acc, 32'd0);
        check("clear_result_16", result, 32'd16);
        idle(2);

        // Randomized operations
        for (int n = 0; n < 24; n++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = (n % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            rb = (n % 4 == 1) ? 32'($urandom_range(0, 255)) : $urandom;
            do_op(ra, rb, 1'($urandom), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 32)) : 0);
            if ($urandom_range(0, 5) == 0) clear_acc();
            else idle(int'($urandom_range(0, 3)));
        end
        idle(5);
        check("final_acc", acc, acc_m);
        check("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mac_unit.md
# mac_unit

Sequential shift-add multiply / multiply-accumulate unit in the execute stage. It consumes `alu_control` and `mac_select` from ALU control together with the two register operands, and produces the low DATA_W bits of `a*b` (MUL) or `acc + a*b` (MAC). It holds the architectural accumulator and raises `busy` so the pipeline stalls while an operation is in flight.

## Interface
- `DATA_W`, 32: operand, product, accumulator and result width.
- `MUL_OP`, 4'd8: ALU control code that requests a multiply.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  request; sampled only when the unit is not busy.
- `alu_control`  in  4  ALU control code; `start` is accepted only when this equals `MUL_OP`.
- `mac_select`  in  1  sampled with `start`: 1 = MAC, 0 = plain MUL.
- `operand_a`  in  DATA_W  multiplicand; sampled with `start`.
- `operand_b`  in  DATA_W  multiplier; sampled with `start`.
- `acc_clear`  in  1  clears the accumulator to 0 at the next edge.
- `busy`  out  1  high in RUN (pipeline stall).
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  DATA_W  registered result; holds its value until the next completion.
- `acc`  out  DATA_W  current accumulator value.

## Operation
- States: IDLE, RUN, DONE. Encoding 2 bits: IDLE=0, RUN=1, DONE=2. State 3 returns to IDLE.
- Accept condition: `start && alu_control==MUL_OP && state!=RUN`.
- IDLE: on accept, load mcand=`operand_a`, mplier=`operand_b`, prod=0, cnt=0, and latch `mac_select`; go to RUN. Otherwise stay in IDLE.
- RUN: each cycle:
  - if mplier[0] is 1, prod += mcand (mod 2^DATA_W);
  - mcand <<= 1; mplier >>= 1; cnt++.
  - The iteration with cnt==DATA_W-1 is the last one. At that edge: go to DONE; `result` <= mac ? acc+final_prod : final_prod (both mod 2^DATA_W); if mac, acc <= acc+final_prod.
- DONE: `done`=1 for this cycle. An accept in DONE goes directly to RUN (back-to-back). Otherwise go to IDLE.
- Every iteration runs; there is no early termination.
- `start` during RUN is ignored and is not queued. A non-MUL `alu_control` never starts the unit.
- `acc_clear`:
  - sets acc to 0 at the next edge in any state;
  - if it coincides with a MAC final edge, the clear wins for `acc`, while `result` still equals old acc + product.
- Arithmetic is unsigned and truncated to DATA_W. This gives correct low bits for signed operands as well.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `result`=0, `acc`=0, cnt=0.
- `rst` mid-operation aborts the operation. No `done` is produced and `acc` is not updated.
- Latency:
  - `start` accepted in cycle 0;
  - `busy`=1 in cycles 1..DATA_W;
  - `done`=1 and `result` valid in cycle DATA_W+1 (cycle 33 for DATA_W=32).
- Throughput: one operation per DATA_W+1 cycles when back-to-back starts are issued in DONE.
- `busy` and `done` are decoded from the registered state only; they have no combinational path from the inputs.
- `acc` and `result` change only at a MAC/MUL final edge, at `acc_clear`, or at reset.

## Structure
- Shared package/header holds:
  - the ALU control codes (AND=0, OR=1, ADD=2, SLL=3, SRL=4, SUB=6, SLT=7, MUL=8), also used by ALU control and the ALU;
  - the mac_unit state encodings.
- One sub-module, `shift_add_core`, is natural. It holds the mcand/mplier/prod registers and cnt, has load/step controls and a last flag, and has no knowledge of accumulate. The FSM, accumulator and result register stay in `mac_unit`.

## Test plan
- MUL 7 × 6, `mac_select`=0 → `done` in cycle 33 with `result`=42; `acc` stays 0; `busy` high in cycles 1..32 only.
- MAC 3 × 4 then MAC 5 × 5, the second issued back-to-back in the DONE cycle → `result`=12 then 37; `acc`=37; second `done` 33 cycles after the first.
- Overflow: MUL 0xFFFFFFFF × 2 → 0xFFFFFFFE; MAC 0x80000000 × 2 with acc=5 → `result`=5, `acc`=5.
- Rejections:
  - `start` with `alu_control`=ADD_OP (2) → stays IDLE, `busy`=0, no `done`;
  - `start` pulsed in RUN cycle 10 → ignored, exactly one `done`.
- `rst` asserted in RUN cycle 15 of a MAC (acc=9 beforehand) → next cycle: IDLE, `acc`=0, `result`=0, no `done`.
- `acc_clear` coinciding with the final edge of MAC 2 × 3 (acc=10) → `result`=16, `acc`=0 afterwards.
